cand_match_mem_paged: RTL
=========================

# cand_match_mem_paged

Parametrised, multi-page candidate-match memory with internal entry counting. It is the next generation of the CM buffer between the MatchEngine and the MatchCalculator. The writer streams candidates for one BX into a page selected by the BX, and the block generates write addresses itself. Entry counts are published per page only when the writer commits, and the reader sees a BRAM-style registered read port plus the committed count of any page.

## Interface
Parameters:
- DATA_W, 14, candidate word width
- ADDR_W, 7, per-page address width; DEPTH = 2**ADDR_W entries per page
- NPAGE_BITS, 1, page-select width; NPAGE = 2**NPAGE_BITS pages
- BX_W, 3, BX field width (must be >= NPAGE_BITS)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wr_start  in  1  one-cycle pulse; opens page wr_bx[NPAGE_BITS-1:0] for filling
- wr_bx  in  BX_W  BX of the event being written; sampled on wr_start
- wr_en  in  1  write one candidate
- wr_data  in  DATA_W  candidate word
- wr_commit  in  1  one-cycle pulse; publishes the live count of the open page
- wr_busy  out  1  high while a page is open
- commit_done  out  1  one-cycle pulse, the cycle after the commit takes effect
- overflow  out  NPAGE  sticky per-page flag; set when a write is dropped because the page is full
- rd_en  in  1  read enable
- rd_bx  in  BX_W  page to read, using the low NPAGE_BITS bits
- rd_addr  in  ADDR_W  entry index within the page
- rd_data  out  DATA_W  registered read data
- rd_nentries  out  ADDR_W+1  committed count of page rd_bx; combinational
- drop_cnt  out  8  dropped-write counter (see Configuration)

## Operation
- Storage is a single RAM of NPAGE*DEPTH words. The physical address is {page, index}. RAM contents are not reset.
- The write FSM has two states, IDLE and FILL.
  - IDLE, wr_start: latch page P = wr_bx low bits, set live count to 0, clear overflow[P], go to FILL.
  - FILL, wr_en:
    - If live < DEPTH: write wr_data at {P, live[ADDR_W-1:0]} and increment live.
    - Otherwise drop the write and set overflow[P].
  - FILL, wr_commit: committed[P] <= live, go to IDLE, pulse commit_done on the next cycle.
  - FILL, wr_start (restart without commit): treat as a new open. Old committed[P] is unchanged, and the new page and count are latched.
- Simultaneous events:
  - wr_start and wr_en together: the open takes effect first. The word is written at index 0 and live becomes 1.
  - wr_en and wr_commit together: the write is included in the published count (committed = live + 1 if not full).
  - wr_start and wr_commit together in FILL: the commit for the old page applies, then the new page opens. The FSM stays in FILL.
- IDLE with wr_en or wr_commit: ignored, with no state change.
- wr_busy = (state == FILL).
- Count width is ADDR_W+1, so a full page reports exactly DEPTH. The live count saturates at DEPTH and never wraps.
- Reads: when rd_en is high, rd_data <= RAM[{rd_bx page, rd_addr}]. When rd_en is low, rd_data holds its value. rd_addr is not checked against committed; reading beyond the count returns stale data.
- Same-address read and write in the same cycle is read-first: the old word is returned.
- rd_nentries reflects committed[] only and never the live count, so a reader of a page being refilled sees the previous commit until wr_commit.

## Timing
- Reset values: state IDLE, wr_busy 0, commit_done 0, overflow all 0, rd_data 0, committed[] all 0, live 0, drop_cnt 0.
- Write latency is 1 cycle: data written at edge N is readable with rd_en at edge N+1, and appears on rd_data after edge N+1.
- Read latency is 1 cycle from rd_en/rd_addr to rd_data.
- committed[P] updates at the edge sampling wr_commit. rd_nentries shows it immediately after that edge. commit_done is high for the following cycle.
- An assertion of reset mid-FILL discards the open page and clears all committed counts. No commit_done is issued.

## Configuration
- CAND_MATCH_MEM_DROP_CNT_EN defined:
  - drop_cnt increments on every dropped write (wr_en in FILL while live == DEPTH).
  - It saturates at 255 and is cleared only by reset.
- Undefined: drop_cnt is tied to 0 and no counter logic is built. Behaviour of overflow is unchanged.

## Test plan
- Basic fill: DATA_W=14, ADDR_W=7. wr_start with bx=3 (page 1), then write 0x0A1, 0x0A2, 0x0A3, then commit -> rd_nentries(bx=1) = 3; rd_addr 0..2 read back 0x0A1..0x0A3 one cycle later; commit_done pulses once.
- Overflow: write 130 words into page 0, then commit -> committed = 128; overflow[0] = 1; drop_cnt = 2 with macro, 0 without. The next wr_start to page 0 clears overflow[0].
- Double-buffering: commit 5 entries to page 0. Open page 0 again and write 2 entries without committing -> rd_nentries(bx=0) stays 5. After the commit it becomes 2.
- Edge collisions:
  - wr_start together with wr_en (data 0x111) -> index 0 = 0x111.
  - wr_en together with wr_commit after 3 writes -> committed = 4.
  - Read-first: same-address read and write -> rd_data returns the old word.
- Reset mid-fill: commit 4 entries to page 1, then open page 0 and write 2. Assert reset -> all counts 0, wr_busy 0, rd_data 0. Writes in IDLE after reset are ignored.

Source files
------------

// File: rtl/cand_match_mem_paged_if.sv
// Candidate-match memory bus: writer stream, commit handshake and read port.
// master drives writes/reads; slave is the memory.
interface cand_match_mem_paged_if #(
  parameter int DATA_W     = 14,
  parameter int ADDR_W     = 7,
  parameter int NPAGE_BITS = 1,
  parameter int BX_W       = 3
);
  localparam int NPAGE = 2**NPAGE_BITS;

  logic              wr_start;
  logic [BX_W-1:0]   wr_bx;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_commit;
  logic              wr_busy;
  logic              commit_done;
  logic [NPAGE-1:0]  overflow;
  logic              rd_en;
  logic [BX_W-1:0]   rd_bx;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   rd_nentries;
  logic [7:0]        drop_cnt;

  modport master (
    output wr_start, wr_bx, wr_en, wr_data, wr_commit,
    output rd_en, rd_bx, rd_addr,
    input  wr_busy, commit_done, overflow,
    input  rd_data, rd_nentries, drop_cnt
  );

  modport slave (
    input  wr_start, wr_bx, wr_en, wr_data, wr_commit,
    input  rd_en, rd_bx, rd_addr,
    output wr_busy, commit_done, overflow,
    output rd_data, rd_nentries, drop_cnt
  );
endinterface

// File: rtl/cand_match_mem_paged.sv
// Paged candidate-match memory: BX-selected page fill with commit-published counts.
// Ports: clk, reset (async, active-low), bus (slave). Option: CAND_MATCH_MEM_DROP_CNT_EN.
module cand_match_mem_paged #(
  parameter int DATA_W     = 14,
  parameter int ADDR_W     = 7,
  parameter int NPAGE_BITS = 1,
  parameter int BX_W       = 3
) (
  input  logic clk,
  input  logic reset,
  cand_match_mem_paged_if.slave bus
);
  localparam int NPAGE = 2**NPAGE_BITS;
  localparam int DEPTH = 2**ADDR_W;
  localparam int PA_W  = NPAGE_BITS + ADDR_W;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t                  r_state;
  logic [NPAGE_BITS-1:0]   r_page;
  logic [ADDR_W:0]         r_live;
  logic [ADDR_W:0]         r_committed [NPAGE];
  logic [NPAGE-1:0]        r_overflow;
  logic                    r_commit_done;
  logic [DATA_W-1:0]       r_rd_data;
  logic [DATA_W-1:0]       r_mem [NPAGE*DEPTH];

  logic                    w_fill;
  logic [NPAGE_BITS-1:0]   w_wr_page;
  logic [ADDR_W:0]         w_wr_live;
  logic                    w_wr_act;
  logic                    w_do_write;
  logic                    w_drop;
  logic [ADDR_W:0]         w_live_nxt;
  logic                    w_commit;
  logic [ADDR_W:0]         w_commit_cnt;
  logic [PA_W-1:0]         w_waddr;
  logic [PA_W-1:0]         w_raddr;
  logic                    w_unused;

  // An open in the same cycle redirects any write to index 0 of the new page.
  always_comb begin
    w_fill     = (r_state == S_FILL);
    w_wr_page  = r_page;
    w_wr_live  = r_live;
    if (bus.wr_start) begin
      w_wr_page = bus.wr_bx[NPAGE_BITS-1:0];
      w_wr_live = '0;
    end
    w_wr_act   = bus.wr_en && (bus.wr_start || w_fill);
    w_do_write = w_wr_act && (w_wr_live != FULL);
    w_drop     = w_wr_act && (w_wr_live == FULL);
    w_live_nxt = w_wr_live + {{ADDR_W{1'b0}}, w_do_write};
    w_commit   = w_fill && bus.wr_commit;
    // Commit with a simultaneous open closes the old page without the new write.
    w_commit_cnt = bus.wr_start ? r_live : w_live_nxt;
    w_waddr    = {w_wr_page, w_wr_live[ADDR_W-1:0]};
    w_raddr    = {bus.rd_bx[NPAGE_BITS-1:0], bus.rd_addr};
  end

  assign w_unused = ^{bus.wr_bx, bus.rd_bx, w_drop};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_page        <= '0;
      r_live        <= '0;
      r_overflow    <= '0;
      r_commit_done <= 1'b0;
      for (int i = 0; i < NPAGE; i++) r_committed[i] <= '0;
    end else begin
      r_commit_done <= w_commit;
      if (w_commit) begin
        r_committed[r_page] <= w_commit_cnt;
        r_state             <= S_IDLE;
      end
      if (w_drop) r_overflow[w_wr_page] <= 1'b1;
      if (bus.wr_start) begin
        r_state               <= S_FILL;
        r_page                <= w_wr_page;
        r_live                <= w_live_nxt;
        r_overflow[w_wr_page] <= 1'b0;
      end else if (w_fill) begin
        r_live <= w_live_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_write) r_mem[w_waddr] <= bus.wr_data;
  end

  // Non-blocking read of r_mem gives read-first on address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rd_data <= '0;
    else if (bus.rd_en) r_rd_data <= r_mem[w_raddr];
  end

`ifdef CAND_MATCH_MEM_DROP_CNT_EN
  logic [7:0] r_drop_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 8'hFF)
      r_drop_cnt <= r_drop_cnt + 8'd1;
  end
  assign bus.drop_cnt = r_drop_cnt;
`else
  assign bus.drop_cnt = '0;
`endif

  assign bus.wr_busy     = w_fill;
  assign bus.commit_done = r_commit_done;
  assign bus.overflow    = r_overflow;
  assign bus.rd_data     = r_rd_data;
  assign bus.rd_nentries = r_committed[bus.rd_bx[NPAGE_BITS-1:0]];
endmodule
